// File: rtl/reorder_pkg.sv
// Shared types and constants for the reorder sequencer: FSM states,
// packet_status bit positions and a ceil-log2 helper.
package reorder_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  localparam int STATUS_RESOLVED = 0;
  localparam int STATUS_PASS     = 1;

  function automatic int CLOG2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reorder_sequencer_mod_counter.sv
// Wrapping modulo counter; MODULUS need not be a power of two.
module mod_counter #(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == LAST) ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/reorder_sequencer.sv
// Reorder tag owner: allocates tags in arrival order and releases verdicts
// to the circular buffer strictly in allocation order.
module reorder_sequencer
  import reorder_pkg::*;
#(
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 cb_back_pressuring,
  output logic [TAG_WIDTH-1:0] cb_reorder_tag,
  input  logic [1:0]           cb_rd_packet_status,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_pass,
  output logic                 retire_valid,
  output logic [TAG_WIDTH-1:0] retire_tag,
  output logic [TAG_WIDTH:0]   occupancy
);

  localparam logic [TAG_WIDTH:0] SIZE = (TAG_WIDTH + 1)'(CIRCULAR_BUFFER_SIZE);

  state_t               state, state_next;
  logic [TAG_WIDTH:0]   count, count_next;
  logic [TAG_WIDTH-1:0] head, tail;
  logic                 alloc, retire;

  assign alloc  = in_valid && in_ready;
  assign retire = out_valid && out_ready;

  mod_counter #(.WIDTH(TAG_WIDTH), .MODULUS(CIRCULAR_BUFFER_SIZE)) u_head (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .value (head)
  );

  mod_counter #(.WIDTH(TAG_WIDTH), .MODULUS(CIRCULAR_BUFFER_SIZE)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .inc   (alloc),
    .value (tail)
  );

  always_comb begin
    count_next = count;
    case ({alloc, retire})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (count != '0) state_next = ST_WAIT;
      ST_WAIT:  if (cb_rd_packet_status[STATUS_RESOLVED]) state_next = ST_EMIT;
      ST_EMIT:  if (retire) state_next = (count_next != '0) ? ST_WAIT : ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // in_ready is precomputed from count_next so it stays register-driven and
  // a same-cycle retire cannot reopen intake combinationally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      count    <= '0;
      in_ready <= 1'b1;
      out_tag  <= '0;
      out_pass <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      in_ready <= (count_next != SIZE);
      if (state == ST_WAIT && cb_rd_packet_status[STATUS_RESOLVED]) begin
        out_tag  <= head;
        out_pass <= cb_rd_packet_status[STATUS_PASS];
      end
    end
  end

  assign out_valid          = (state == ST_EMIT);
  assign retire_valid       = retire;
  assign retire_tag         = head;
  assign alloc_tag          = tail;
  assign cb_reorder_tag     = head;
  assign cb_back_pressuring = !in_ready;
  assign occupancy          = count;

endmodule

// File: tb/tb_reorder_sequencer.sv
// Directed bench for reorder_sequencer with a behavioural packet_status table.
module tb_reorder_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] alloc_tag;
  logic       cb_back_pressuring;
  logic [5:0] cb_reorder_tag;
  logic [1:0] cb_rd_packet_status;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_tag;
  logic       out_pass;
  logic       retire_valid;
  logic [5:0] retire_tag;
  logic [6:0] occupancy;

  logic [63:0] tbl_res  = '0;
  logic [63:0] tbl_pass = '0;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [5:0] tag;
    logic       pass;
  } ent_t;

  always #5 clk = ~clk;

  assign cb_rd_packet_status = {tbl_pass[cb_reorder_tag], tbl_res[cb_reorder_tag]};

  reorder_sequencer #(.TAG_WIDTH(6), .CIRCULAR_BUFFER_SIZE(50)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .alloc_tag           (alloc_tag),
    .cb_back_pressuring  (cb_back_pressuring),
    .cb_reorder_tag      (cb_reorder_tag),
    .cb_rd_packet_status (cb_rd_packet_status),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_tag             (out_tag),
    .out_pass            (out_pass),
    .retire_valid        (retire_valid),
    .retire_tag          (retire_tag),
    .occupancy           (occupancy)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
    vectors++; if (out_tag !== 6'd0 || out_pass !== 1'b0) begin miscompares++; $display("FAIL rst_out_tag_pass got %0h/%0h want 0/0", out_tag, out_pass); end
    vectors++; if (retire_valid !== 1'b0 || retire_tag !== 6'd0) begin miscompares++; $display("FAIL rst_retire got %0h/%0h want 0/0", retire_valid, retire_tag); end
    vectors++; if (in_ready !== 1'b1 || cb_back_pressuring !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %0h/%0h want 1/0", in_ready, cb_back_pressuring); end
    vectors++; if (alloc_tag !== 6'd0 || cb_reorder_tag !== 6'd0) begin miscompares++; $display("FAIL rst_tags got %0h/%0h want 0/0", alloc_tag, cb_reorder_tag); end
    vectors++; if (occupancy !== 7'd0) begin miscompares++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 7'd0 || cb_reorder_tag !== 6'd0) begin
        miscompares++;
        $display("FAIL idle_cycle%0d got rdy=%0h vld=%0h occ=%0d head=%0d want 1/0/0/0", c, in_ready, out_valid, occupancy, cb_reorder_tag);
      end
    end
  endtask

  task automatic test_in_order();
    logic [2:0] pv;
    pv = 3'b101;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (alloc_tag !== 6'(i) || in_ready !== 1'b1) begin miscompares++; $display("FAIL inorder_alloc%0d got %0d want %0d", i, alloc_tag, i); end
      tbl_res[i]  = 1'b1;
      tbl_pass[i] = pv[i];
      tick();
    end
    in_valid = 1'b0;
    for (int k = 2; k < 8; k++) begin
      #1;
      vectors++; if (out_valid !== 1'((k % 2) == 0)) begin miscompares++; $display("FAIL inorder_vld_k%0d got %0h want %0h", k, out_valid, (k % 2) == 0); end
      if ((k % 2) == 0) begin
        vectors++;
        if (out_tag !== 6'((k - 2) / 2) || out_pass !== pv[(k - 2) / 2] || retire_valid !== 1'b1 || retire_tag !== 6'((k - 2) / 2)) begin
          miscompares++;
          $display("FAIL inorder_emit_k%0d got tag=%0d pass=%0h ret=%0h rtag=%0d want tag=%0d pass=%0h ret=1", k, out_tag, out_pass, retire_valid, retire_tag, (k - 2) / 2, pv[(k - 2) / 2]);
        end
      end else begin
        vectors++; if (retire_valid !== 1'b0) begin miscompares++; $display("FAIL inorder_noret_k%0d got %0h want 0", k, retire_valid); end
      end
      tick();
    end
    vectors++; if (occupancy !== 7'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL inorder_drain got occ=%0d vld=%0h want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tbl_res[i]  = 1'b0;
      tbl_pass[i] = (i != 1);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 3; k < 21; k++) begin
      if (k == 5) tbl_res[3] = 1'b1;
      if (k == 6) tbl_res[2] = 1'b1;
      if (k == 7) tbl_res[1] = 1'b1;
      if (k == 20) tbl_res[0] = 1'b1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_early_vld_k%0d got %0h want 0", k, out_valid); end
      tick();
    end
    for (int n = 0; n < 4; n++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_tag !== 6'(n) || out_pass !== 1'(n != 1) || retire_tag !== 6'(n)) begin
        miscompares++;
        $display("FAIL ooo_emit%0d got vld=%0h tag=%0d pass=%0h want 1/%0d/%0h", n, out_valid, out_tag, out_pass, n, n != 1);
      end
      tick();
      if (n < 3) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_gap%0d got %0h want 0", n, out_valid); end
        tick();
      end
    end
    vectors++; if (occupancy !== 7'd0) begin miscompares++; $display("FAIL ooo_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (alloc_tag !== 6'(i) || in_ready !== 1'b1) begin
        vectors++; miscompares++;
        $display("FAIL full_alloc%0d got tag=%0d rdy=%0h want %0d/1", i, alloc_tag, in_ready, i);
      end
      tbl_res[i] = 1'b0;
      tick();
    end
    vectors++; if (in_ready !== 1'b0 || cb_back_pressuring !== 1'b1 || occupancy !== 7'd50) begin miscompares++; $display("FAIL full_state got rdy=%0h bp=%0h occ=%0d want 0/1/50", in_ready, cb_back_pressuring, occupancy); end
    tick();
    vectors++; if (occupancy !== 7'd50 || alloc_tag !== 6'd0) begin miscompares++; $display("FAIL full_hold got occ=%0d tag=%0d want 50/0", occupancy, alloc_tag); end
    tbl_res[0]  = 1'b1;
    tbl_pass[0] = 1'b0;
    tick();
    out_ready = 1'b1;
    #1;
    vectors++; if (retire_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL full_retire got ret=%0h rdy=%0h want 1/0", retire_valid, in_ready); end
    tick();
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1 || cb_back_pressuring !== 1'b0 || alloc_tag !== 6'd0 || occupancy !== 7'd49) begin miscompares++; $display("FAIL full_reopen got rdy=%0h bp=%0h tag=%0d occ=%0d want 1/0/0/49", in_ready, cb_back_pressuring, alloc_tag, occupancy); end
    tbl_res[0] = 1'b0;
    tick();
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0 || occupancy !== 7'd50 || alloc_tag !== 6'd1) begin miscompares++; $display("FAIL full_refill got rdy=%0h occ=%0d tag=%0d want 0/50/1", in_ready, occupancy, alloc_tag); end
  endtask

  task automatic test_back_pressure();
    bit seen;
    do_reset();
    tbl_res[0]  = 1'b1;
    tbl_pass[0] = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL bp_timeout got out_valid=%0h want 1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_tag !== 6'd0 || out_pass !== 1'b1 || retire_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d got vld=%0h tag=%0d pass=%0h ret=%0h want 1/0/1/0", c, out_valid, out_tag, out_pass, retire_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (retire_valid !== 1'b1 || retire_tag !== 6'd0) begin miscompares++; $display("FAIL bp_release got ret=%0h tag=%0d want 1/0", retire_valid, retire_tag); end
    tick();
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0 || occupancy !== 7'd0) begin miscompares++; $display("FAIL bp_after got vld=%0h occ=%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_random_wrap();
    ent_t q[$];
    ent_t e;
    int   model_count, alloc_n, ret_n, cycles;
    bit   did_alloc, did_ret;
    logic p;
    do_reset();
    model_count = 0; alloc_n = 0; ret_n = 0; cycles = 0;
    while (ret_n < 120 && cycles < 3000) begin
      in_valid  = (alloc_n < 120);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      vectors++; if (occupancy !== 7'(model_count) || in_ready !== 1'(model_count != 50)) begin miscompares++; $display("FAIL wrap_occ_c%0d got occ=%0d rdy=%0h want %0d", cycles, occupancy, in_ready, model_count); end
      did_alloc = in_valid && in_ready;
      did_ret   = retire_valid;
      if (did_alloc) begin
        p = 1'(((alloc_n * 5) % 3) != 0);
        vectors++; if (alloc_tag !== 6'(alloc_n % 50)) begin miscompares++; $display("FAIL wrap_alloc%0d got %0d want %0d", alloc_n, alloc_tag, alloc_n % 50); end
        tbl_res[alloc_tag]  = 1'b1;
        tbl_pass[alloc_tag] = p;
        e.tag  = alloc_tag;
        e.pass = p;
        q.push_back(e);
        alloc_n++;
      end
      if (did_ret) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL wrap_spurious_retire got tag=%0d want none", retire_tag);
        end else begin
          e = q.pop_front();
          if (retire_tag !== e.tag || out_tag !== e.tag || out_pass !== e.pass) begin
            miscompares++;
            $display("FAIL wrap_retire%0d got tag=%0d/%0d pass=%0h want %0d/%0h", ret_n, retire_tag, out_tag, out_pass, e.tag, e.pass);
          end
        end
        ret_n++;
      end
      model_count = model_count + int'(did_alloc) - int'(did_ret);
      tick();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++; if (ret_n != 120 || alloc_n != 120 || q.size() != 0) begin miscompares++; $display("FAIL wrap_totals got alloc=%0d ret=%0d left=%0d want 120/120/0", alloc_n, ret_n, q.size()); end
    vectors++; if (occupancy !== 7'd0) begin miscompares++; $display("FAIL wrap_final_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      tbl_res[alloc_tag]  = 1'b1;
      tbl_pass[alloc_tag] = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    vectors++; if (occupancy !== 7'd10 || out_valid !== 1'b1 || alloc_tag !== 6'd30) begin miscompares++; $display("FAIL mid_pre got occ=%0d vld=%0h tail=%0d want 10/1/30", occupancy, out_valid, alloc_tag); end
    rst = 1'b0;
    #1;
    vectors++; if (retire_valid !== 1'b0) begin miscompares++; $display("FAIL mid_noret got %0h want 0", retire_valid); end
    tick();
    rst = 1'b1;
    vectors++; if (occupancy !== 7'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || cb_reorder_tag !== 6'd0) begin miscompares++; $display("FAIL mid_post got occ=%0d vld=%0h rdy=%0h head=%0d want 0/0/1/0", occupancy, out_valid, in_ready, cb_reorder_tag); end
    in_valid = 1'b1;
    tbl_res[0] = 1'b0;
    #1;
    vectors++; if (alloc_tag !== 6'd0) begin miscompares++; $display("FAIL mid_fresh_alloc got %0d want 0", alloc_tag); end
    tick();
    in_valid = 1'b0;
    vectors++; if (occupancy !== 7'd1 || alloc_tag !== 6'd1) begin miscompares++; $display("FAIL mid_fresh_occ got occ=%0d tail=%0d want 1/1", occupancy, alloc_tag); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_full();
    test_back_pressure();
    test_random_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
